// File: rtl/char_fsm_pkg.sv
// Shared state encodings and default phase lengths for the character action FSM,
// also used by the renderer and hit-detection logic.
package char_fsm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LEFT       = 4'd1,
    ST_RIGHT      = 4'd2,
    ST_ATK_START  = 4'd3,
    ST_ATK_ACTIVE = 4'd4,
    ST_ATK_RECOV  = 4'd5,
    ST_DIR_START  = 4'd6,
    ST_DIR_ACTIVE = 4'd7,
    ST_DIR_RECOV  = 4'd8,
    ST_STUN       = 4'd9,
    ST_BLOCKSTUN  = 4'd10
  } state_e;

  localparam int unsigned DEF_CNT_W    = 5;
  localparam int unsigned DEF_N_START  = 5;
  localparam int unsigned DEF_N_ACTIVE = 2;
  localparam int unsigned DEF_N_RECOV  = 16;
  localparam int unsigned DEF_D_START  = 4;
  localparam int unsigned DEF_D_ACTIVE = 3;
  localparam int unsigned DEF_D_RECOV  = 15;
  localparam int unsigned DEF_BUF_WIN  = 4;

  function automatic logic is_stun(state_e s);
    return (s == ST_STUN) || (s == ST_BLOCKSTUN);
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Phase counter: synchronous clear, load, and saturating decrement, with a flag
// marking the final tick of the current phase.
module frame_down_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/char_action_fsm.sv
// Per-character action FSM: walking, neutral and directional attacks with an input
// buffer in recovery, and hit/block stun driven by the hit-detection logic.
module char_action_fsm
  import char_fsm_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned N_START  = DEF_N_START,
  parameter int unsigned N_ACTIVE = DEF_N_ACTIVE,
  parameter int unsigned N_RECOV  = DEF_N_RECOV,
  parameter int unsigned D_START  = DEF_D_START,
  parameter int unsigned D_ACTIVE = DEF_D_ACTIVE,
  parameter int unsigned D_RECOV  = DEF_D_RECOV,
  parameter int unsigned BUF_WIN  = DEF_BUF_WIN
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic             char_no,
  input  logic             KEY_LEFT,
  input  logic             KEY_RIGHT,
  input  logic             KEY_ATTACK,
  input  logic [CNT_W-1:0] load_frame,
  input  logic             hit_kind,
  output logic [3:0]       STATE,
  output logic [CNT_W-1:0] FrameCounter,
  output logic             attack_dir,
  output logic             button_flag,
  output logic             block_flag,
  output logic             hitbox_active,
  output logic             buf_pending
);

  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  if ((CNT_W == 0) || (CNT_W > 31)) begin : g_bad_cnt_w
    $error("char_action_fsm: CNT_W must be in 1..31");
  end
  if ((N_START == 0) || (N_START > CNT_MAX) || (N_ACTIVE == 0) || (N_ACTIVE > CNT_MAX) ||
      (N_RECOV == 0) || (N_RECOV > CNT_MAX) || (D_START == 0) || (D_START > CNT_MAX) ||
      (D_ACTIVE == 0) || (D_ACTIVE > CNT_MAX) || (D_RECOV == 0) || (D_RECOV > CNT_MAX) ||
      (BUF_WIN > CNT_MAX)) begin : g_bad_len
    $error("char_action_fsm: phase lengths must fit in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] N_START_C  = CNT_W'(N_START);
  localparam logic [CNT_W-1:0] N_ACTIVE_C = CNT_W'(N_ACTIVE);
  localparam logic [CNT_W-1:0] N_RECOV_C  = CNT_W'(N_RECOV);
  localparam logic [CNT_W-1:0] D_START_C  = CNT_W'(D_START);
  localparam logic [CNT_W-1:0] D_ACTIVE_C = CNT_W'(D_ACTIVE);
  localparam logic [CNT_W-1:0] D_RECOV_C  = CNT_W'(D_RECOV);
  localparam logic [CNT_W-1:0] BUF_WIN_C  = CNT_W'(BUF_WIN);
  localparam bit               BUF_EN     = (BUF_WIN != 0);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic             buf_q, buf_d;
  logic             cnt_clear, cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0] cnt_load_val, cnt;

  frame_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .last     (cnt_last)
  );

  // The counter is zero in every non-timed state, so IDLE/LEFT/RIGHT never touch it.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    buf_d        = buf_q;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_clear = 1'b1;
      buf_d     = 1'b0;
    end else if (frame_tick) begin
      if ((load_frame != '0) && !is_stun(state_q)) begin
        state_d      = hit_kind ? ST_BLOCKSTUN : ST_STUN;
        cnt_load     = 1'b1;
        cnt_load_val = load_frame;
        buf_d        = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (KEY_LEFT && KEY_RIGHT) begin
              state_d = ST_IDLE;
            end else if (KEY_LEFT) begin
              state_d = ST_LEFT;
            end else if (KEY_RIGHT) begin
              state_d = ST_RIGHT;
            end else if (KEY_ATTACK) begin
              state_d      = ST_ATK_START;
              cnt_load     = 1'b1;
              cnt_load_val = N_START_C;
            end
          end
          ST_LEFT, ST_RIGHT: begin
            if (KEY_ATTACK) begin
              state_d      = ST_DIR_START;
              cnt_load     = 1'b1;
              cnt_load_val = D_START_C;
              dir_d        = (state_q == ST_RIGHT);
            end else if (KEY_LEFT ^ KEY_RIGHT) begin
              state_d = KEY_RIGHT ? ST_RIGHT : ST_LEFT;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_ATK_START, ST_ATK_ACTIVE, ST_DIR_START, ST_DIR_ACTIVE: begin
            if (cnt_last) begin
              cnt_load = 1'b1;
              case (state_q)
                ST_ATK_START:  begin state_d = ST_ATK_ACTIVE; cnt_load_val = N_ACTIVE_C; end
                ST_ATK_ACTIVE: begin state_d = ST_ATK_RECOV;  cnt_load_val = N_RECOV_C;  end
                ST_DIR_START:  begin state_d = ST_DIR_ACTIVE; cnt_load_val = D_ACTIVE_C; end
                default:       begin state_d = ST_DIR_RECOV;  cnt_load_val = D_RECOV_C;  end
              endcase
            end else begin
              cnt_dec = 1'b1;
            end
          end
          // Only a press buffered on an earlier tick chains into the next attack.
          ST_ATK_RECOV, ST_DIR_RECOV: begin
            if (BUF_EN && KEY_ATTACK && (cnt <= BUF_WIN_C)) begin
              buf_d = 1'b1;
            end
            if (cnt_last) begin
              buf_d = 1'b0;
              if (buf_q) begin
                cnt_load = 1'b1;
                if (KEY_LEFT ^ KEY_RIGHT) begin
                  state_d      = ST_DIR_START;
                  cnt_load_val = D_START_C;
                  dir_d        = KEY_RIGHT;
                end else begin
                  state_d      = ST_ATK_START;
                  cnt_load_val = N_START_C;
                end
              end else begin
                state_d   = ST_IDLE;
                cnt_clear = 1'b1;
              end
            end else begin
              cnt_dec = 1'b1;
            end
          end
          ST_STUN, ST_BLOCKSTUN: begin
            if (cnt_last) begin
              state_d   = ST_IDLE;
              cnt_clear = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
          default: begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      buf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      buf_q   <= buf_d;
    end
  end

  assign STATE         = state_q;
  assign FrameCounter  = cnt;
  assign attack_dir    = dir_q;
  assign buf_pending   = buf_q;
  assign button_flag   = KEY_LEFT | KEY_RIGHT;
  assign block_flag    = (!char_no && (state_q == ST_LEFT)) ||
                         (char_no && (state_q == ST_RIGHT)) ||
                         (state_q == ST_BLOCKSTUN);
  assign hitbox_active = (state_q == ST_ATK_ACTIVE) || (state_q == ST_DIR_ACTIVE);

endmodule

// File: tb/tb_char_action_fsm.sv
// Bench for char_action_fsm: a fixed vector table, hand-written timing sequences,
// and randomized traffic compared against a phase-level model of the character.
module tb_char_action_fsm;

  localparam int N_START  = 5;
  localparam int N_ACTIVE = 2;
  localparam int N_RECOV  = 16;
  localparam int D_START  = 4;
  localparam int D_ACTIVE = 3;
  localparam int D_RECOV  = 15;
  localparam int BUF_WIN  = 4;

  logic       CLOCK = 1'b0;
  logic       RESET_N, frame_tick, enable, char_no;
  logic       KEY_LEFT, KEY_RIGHT, KEY_ATTACK, hit_kind;
  logic [4:0] load_frame;
  logic [3:0] STATE;
  logic [4:0] FrameCounter;
  logic       attack_dir, button_flag, block_flag, hitbox_active, buf_pending;

  char_action_fsm dut (
    .CLOCK         (CLOCK),
    .RESET_N       (RESET_N),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .char_no       (char_no),
    .KEY_LEFT      (KEY_LEFT),
    .KEY_RIGHT     (KEY_RIGHT),
    .KEY_ATTACK    (KEY_ATTACK),
    .load_frame    (load_frame),
    .hit_kind      (hit_kind),
    .STATE         (STATE),
    .FrameCounter  (FrameCounter),
    .attack_dir    (attack_dir),
    .button_flag   (button_flag),
    .block_flag    (block_flag),
    .hitbox_active (hitbox_active),
    .buf_pending   (buf_pending)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit en, ft, l, r, a;
    int lf;
    bit hk, cn;
    int st, cnt, dir, hit, blk;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   m_state, m_cnt, m_dir, m_buf;
  bit   cn_sel;
  int   n3, n4, n5, n10, bad;

  function automatic void check_val(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endfunction

  function automatic int phase_len(int st);
    case (st)
      3: return N_START;
      4: return N_ACTIVE;
      5: return N_RECOV;
      6: return D_START;
      7: return D_ACTIVE;
      8: return D_RECOV;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_dir = 0; m_buf = 0;
  endfunction

  // Character behaviour at phase level: which move is running and how many ticks remain.
  function automatic void model_step(bit en, bit ft, bit l, bit r, bit a, int lf, bit hk);
    int old_buf;
    if (!en) begin
      m_state = 0; m_cnt = 0; m_buf = 0;
      return;
    end
    if (!ft) return;
    if (lf != 0 && m_state != 9 && m_state != 10) begin
      m_state = hk ? 10 : 9; m_cnt = lf; m_buf = 0;
      return;
    end
    old_buf = m_buf;
    case (m_state)
      0: begin
        if (l && !r) m_state = 1;
        else if (r && !l) m_state = 2;
        else if (!l && !r && a) begin m_state = 3; m_cnt = N_START; end
      end
      1, 2: begin
        if (a) begin m_dir = (m_state == 2) ? 1 : 0; m_state = 6; m_cnt = D_START; end
        else if (l != r) m_state = r ? 2 : 1;
        else m_state = 0;
      end
      3, 4, 6, 7: begin
        if (m_cnt > 1) m_cnt--;
        else begin m_state++; m_cnt = phase_len(m_state); end
      end
      5, 8: begin
        if (a && BUF_WIN > 0 && m_cnt <= BUF_WIN) m_buf = 1;
        if (m_cnt > 1) m_cnt--;
        else begin
          m_buf = 0;
          if (old_buf != 0) begin
            if (l != r) begin m_state = 6; m_cnt = D_START; m_dir = r; end
            else begin m_state = 3; m_cnt = N_START; end
          end else begin
            m_state = 0; m_cnt = 0;
          end
        end
      end
      9, 10: begin
        if (m_cnt > 1) m_cnt--;
        else begin m_state = 0; m_cnt = 0; end
      end
      default: begin m_state = 0; m_cnt = 0; end
    endcase
  endfunction

  function automatic void check_output(string tag);
    int exp_blk;
    exp_blk = ((char_no == 1'b0 && m_state == 1) || (char_no == 1'b1 && m_state == 2) ||
               m_state == 10) ? 1 : 0;
    check_val({tag, " STATE"}, int'(STATE), m_state);
    check_val({tag, " FrameCounter"}, int'(FrameCounter), m_cnt);
    check_val({tag, " attack_dir"}, int'(attack_dir), m_dir);
    check_val({tag, " buf_pending"}, int'(buf_pending), m_buf);
    check_val({tag, " button_flag"}, int'(button_flag), int'(KEY_LEFT | KEY_RIGHT));
    check_val({tag, " block_flag"}, int'(block_flag), exp_blk);
    check_val({tag, " hitbox_active"}, int'(hitbox_active), (m_state == 4 || m_state == 7) ? 1 : 0);
  endfunction

  task automatic apply_stimulus(input bit en, input bit ft, input bit l, input bit r, input bit a,
                                input int lf, input bit hk, input bit cn);
    enable = en; frame_tick = ft; KEY_LEFT = l; KEY_RIGHT = r; KEY_ATTACK = a;
    load_frame = 5'(lf); hit_kind = hk; char_no = cn;
    @(posedge CLOCK);
    model_step(en, ft, l, r, a, lf, hk);
    #1;
  endtask

  task automatic tick(input bit l, input bit r, input bit a, input int lf, input bit hk,
                      input string tag);
    apply_stimulus(1'b1, 1'b1, l, r, a, lf, hk, cn_sel);
    check_output(tag);
  endtask

  // Idle ticks until the model reaches the target; the DUT must agree when it does.
  task automatic advance_until(input int st, input int cnt, input int max_ticks, input string tag);
    for (int i = 0; i < max_ticks; i++) begin
      if (m_state == st && (cnt < 0 || m_cnt == cnt)) break;
      tick(1'b0, 1'b0, 1'b0, 0, 1'b0, tag);
    end
    check_val({tag, " reach STATE"}, int'(STATE), st);
  endtask

  task automatic async_reset(input string tag);
    #2 RESET_N = 1'b0;
    #1 model_reset();
    check_output(tag);
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RESET_N = 1'b0; enable = 1'b1; frame_tick = 1'b0; char_no = 1'b0;
    KEY_LEFT = 1'b0; KEY_RIGHT = 1'b0; KEY_ATTACK = 1'b0; load_frame = '0; hit_kind = 1'b0;
    cn_sel = 1'b0;
    model_reset();
    #12;
    check_val("reset STATE", int'(STATE), 0);
    check_val("reset FrameCounter", int'(FrameCounter), 0);
    check_val("reset attack_dir", int'(attack_dir), 0);
    check_val("reset buf_pending", int'(buf_pending), 0);
    check_val("reset hitbox_active", int'(hitbox_active), 0);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    //                 en ft l  r  a  lf hk cn   st cnt dir hit blk
    vecs.push_back(vec_t'{1, 1, 0, 1, 0, 0, 0, 1,  2,  0, 0, 0, 1});
    vecs.push_back(vec_t'{1, 0, 0, 1, 1, 0, 0, 1,  2,  0, 0, 0, 1});
    vecs.push_back(vec_t'{1, 1, 0, 1, 1, 0, 0, 1,  6,  4, 1, 0, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 1,  6,  3, 1, 0, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 1,  6,  2, 1, 0, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 1,  6,  1, 1, 0, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 1,  7,  3, 1, 1, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 1,  7,  2, 1, 1, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 1,  7,  1, 1, 1, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 1,  8, 15, 1, 0, 0});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 7, 1, 1, 10,  7, 1, 0, 1});
    vecs.push_back(vec_t'{1, 1, 0, 0, 0, 3, 0, 1, 10,  6, 1, 0, 1});
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 0, 0, 1, 10,  6, 1, 0, 1});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1,  0,  0, 1, 0, 0});
    vecs.push_back(vec_t'{1, 1, 1, 1, 0, 0, 0, 1,  0,  0, 1, 0, 0});
    vecs.push_back(vec_t'{1, 1, 1, 0, 0, 0, 0, 1,  1,  0, 1, 0, 0});
    vecs.push_back(vec_t'{1, 1, 1, 1, 0, 0, 0, 1,  0,  0, 1, 0, 0});
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].en, vecs[i].ft, vecs[i].l, vecs[i].r, vecs[i].a,
                     vecs[i].lf, vecs[i].hk, vecs[i].cn);
      check_val($sformatf("vec%0d STATE", i), int'(STATE), vecs[i].st);
      check_val($sformatf("vec%0d FrameCounter", i), int'(FrameCounter), vecs[i].cnt);
      check_val($sformatf("vec%0d attack_dir", i), int'(attack_dir), vecs[i].dir);
      check_val($sformatf("vec%0d hitbox_active", i), int'(hitbox_active), vecs[i].hit);
      check_val($sformatf("vec%0d block_flag", i), int'(block_flag), vecs[i].blk);
    end

    // Neutral attack phase durations, with unqualified cycles interleaved.
    cn_sel = 1'b0;
    n3 = 0; n4 = 0; n5 = 0; bad = 0;
    tick(1'b0, 1'b0, 1'b1, 0, 1'b0, "atk");
    for (int i = 0; i < 40; i++) begin
      if (STATE == 4'd3) n3++;
      else if (STATE == 4'd4) begin n4++; if (!hitbox_active) bad++; end
      else if (STATE == 4'd5) n5++;
      else break;
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, cn_sel);
      check_output("atk gap");
      tick(1'b0, 1'b0, 1'b0, 0, 1'b0, "atk");
    end
    check_val("atk start ticks", n3, 5);
    check_val("atk active ticks", n4, 2);
    check_val("atk recov ticks", n5, 16);
    check_val("atk hitbox misses", bad, 0);
    check_val("atk end STATE", int'(STATE), 0);

    // Buffering: a press at FrameCounter=6 is too early, one at 3 chains an attack.
    tick(1'b0, 1'b0, 1'b1, 0, 1'b0, "buf");
    advance_until(5, 6, 40, "buf");
    tick(1'b0, 1'b0, 1'b1, 0, 1'b0, "buf early");
    check_val("buf early buf_pending", int'(buf_pending), 0);
    advance_until(5, 3, 10, "buf");
    tick(1'b0, 1'b0, 1'b1, 0, 1'b0, "buf press");
    check_val("buf press buf_pending", int'(buf_pending), 1);
    tick(1'b0, 1'b0, 1'b0, 0, 1'b0, "buf");
    tick(1'b0, 1'b0, 1'b0, 0, 1'b0, "buf chain");
    check_val("buf chain STATE", int'(STATE), 3);
    check_val("buf chain FrameCounter", int'(FrameCounter), 5);
    check_val("buf chain buf_pending", int'(buf_pending), 0);
    advance_until(0, -1, 40, "buf drain");

    // Blockstun from ATK_ACTIVE lasts 7 ticks; a reload mid-stun is ignored.
    tick(1'b0, 1'b0, 1'b1, 0, 1'b0, "bstun");
    advance_until(4, -1, 10, "bstun");
    tick(1'b0, 1'b0, 1'b0, 7, 1'b1, "bstun hit");
    n10 = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (STATE != 4'd10) break;
      n10++;
      if (!block_flag) bad++;
      tick(1'b0, 1'b0, 1'b0, (i == 2) ? 3 : 0, 1'b0, "bstun");
    end
    check_val("bstun ticks", n10, 7);
    check_val("bstun block misses", bad, 0);

    // enable drop mid-stun returns to IDLE without a frame tick.
    tick(1'b0, 1'b0, 1'b0, 9, 1'b0, "stun");
    tick(1'b0, 1'b0, 1'b0, 0, 1'b0, "stun");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, cn_sel);
    check_val("disable STATE", int'(STATE), 0);
    check_val("disable FrameCounter", int'(FrameCounter), 0);
    check_output("disable");

    // Asynchronous reset in the middle of DIR_ACTIVE.
    tick(1'b0, 1'b1, 1'b0, 0, 1'b0, "rst");
    tick(1'b0, 1'b1, 1'b1, 0, 1'b0, "rst");
    advance_until(7, -1, 10, "rst");
    #2 RESET_N = 1'b0;
    #1;
    check_val("rst STATE", int'(STATE), 0);
    check_val("rst FrameCounter", int'(FrameCounter), 0);
    check_val("rst attack_dir", int'(attack_dir), 0);
    check_val("rst hitbox_active", int'(hitbox_active), 0);
    model_reset();
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      apply_stimulus(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 31)) : 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_output("rand");
      if ($urandom_range(0, 499) == 0) async_reset("rand reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_action_fsm.md
CHAR_ACTION_FSM -- requirements
Module: char_action_fsm

Interface -- parameters (name, default, meaning)
REQ-001 CNT_W, 5, width of FrameCounter and load_frame.
REQ-002 N_START / N_ACTIVE / N_RECOV, 5 / 2 / 16, neutral attack phase lengths in frame ticks.
REQ-003 D_START / D_ACTIVE / D_RECOV, 4 / 3 / 15, directional attack phase lengths in frame ticks.
REQ-004 BUF_WIN, 4, final recovery ticks in which an attack press is buffered; 0 disables buffering.

Interface -- ports (name direction width meaning)
REQ-005 CLOCK in 1, system clock; RESET_N in 1, reset, asynchronous, active-low.
REQ-006 frame_tick in 1, one-cycle pulse; the FSM advances only on cycles with frame_tick=1 and enable=1.
REQ-007 enable in 1, game-running qualifier; char_no in 1, 0=left player, 1=right player.
REQ-008 KEY_LEFT, KEY_RIGHT, KEY_ATTACK in 1 each, active-high (already inverted upstream).
REQ-009 load_frame in CNT_W, stun length request (0=none); hit_kind in 1, 0=hitstun, 1=blockstun.
REQ-010 STATE out 4; FrameCounter out CNT_W; attack_dir out 1 (0=left, 1=right, last directional attack).
REQ-011 button_flag out 1; block_flag out 1; hitbox_active out 1; buf_pending out 1.

Function
REQ-012 Encoding: IDLE=0, LEFT=1, RIGHT=2, ATK_START=3, ATK_ACTIVE=4, ATK_RECOV=5, DIR_START=6, DIR_ACTIVE=7, DIR_RECOV=8, STUN=9, BLOCKSTUN=10; codes 11-15 go to IDLE on the next qualified tick.
REQ-013 enable=0 on any clock edge: STATE=IDLE, FrameCounter=0, buf_pending=0, synchronously, regardless of frame_tick.
REQ-014 Highest priority on a qualified tick: load_frame!=0 while STATE is not STUN/BLOCKSTUN -> STATE=STUN (hit_kind=0) or BLOCKSTUN (hit_kind=1), FrameCounter=load_frame, buf_pending=0.
REQ-015 load_frame!=0 while already in STUN/BLOCKSTUN is ignored (no reload, no extension).
REQ-016 STUN/BLOCKSTUN: FrameCounter=1 -> IDLE; otherwise decrement; the stun lasts exactly load_frame ticks.
REQ-017 IDLE priority: LEFT and RIGHT both held -> stay IDLE; else LEFT -> LEFT; RIGHT -> RIGHT; ATTACK -> ATK_START with FrameCounter=N_START.
REQ-018 LEFT/RIGHT: ATTACK -> DIR_START with FrameCounter=D_START and attack_dir=current direction; else the opposite key alone -> other direction; same key -> stay; no key or both keys -> IDLE.
REQ-019 Every attack phase: FrameCounter>1 -> decrement; FrameCounter=1 -> next phase with FrameCounter loaded to that phase's length; each phase lasts exactly its parameter in ticks.
REQ-020 Phase order: ATK_START->ATK_ACTIVE->ATK_RECOV->IDLE; DIR_START->DIR_ACTIVE->DIR_RECOV->IDLE.
REQ-021 Buffer: KEY_ATTACK=1 on a qualified tick in ATK_RECOV/DIR_RECOV with FrameCounter<=BUF_WIN sets buf_pending.
REQ-022 Recovery end with buf_pending=1: skip IDLE and enter DIR_START if exactly one direction key is held (attack_dir updated), else ATK_START; buf_pending cleared.
REQ-023 button_flag = KEY_LEFT|KEY_RIGHT, combinational.
REQ-024 block_flag = (char_no=0 and STATE=LEFT) or (char_no=1 and STATE=RIGHT) or STATE=BLOCKSTUN, combinational.
REQ-025 hitbox_active = STATE in {ATK_ACTIVE, DIR_ACTIVE}, combinational.
REQ-026 Counter arithmetic is CNT_W-bit unsigned with no wrap: phase lengths are in 1..2^CNT_W-1, enforced by an elaboration-time check.

Reset
REQ-027 RESET_N=0 asynchronously forces STATE=IDLE, FrameCounter=0, attack_dir=0, buf_pending=0; release is synchronised externally.
REQ-028 Reset during any attack or stun phase discards that phase and any buffered press.

Structure
REQ-029 Package char_fsm_pkg holds the state encodings and default phase-length constants, shared with the renderer and hit-detection logic.
REQ-030 One sub-module, frame_down_counter (load, decrement, last-tick flag, CNT_W-parameterised), implements the phase counter.

Verification
REQ-031 Defaults, IDLE, ATTACK pulse -> ATK_START 5 ticks, ATK_ACTIVE 2 ticks (hitbox_active=1), ATK_RECOV 16 ticks, then IDLE.
REQ-032 Hold RIGHT then ATTACK -> DIR_START 4 / DIR_ACTIVE 3 / DIR_RECOV 15 ticks, attack_dir=1; char_no=1 in RIGHT -> block_flag=1.
REQ-033 ATTACK at recovery FrameCounter=3 -> buf_pending=1, then ATK_START directly after the last recovery tick; ATTACK at FrameCounter=6 -> no buffer.
REQ-034 load_frame=7, hit_kind=1 during ATK_ACTIVE -> BLOCKSTUN for 7 ticks with block_flag=1; a second load_frame=3 mid-stun is ignored.
REQ-035 RESET_N low mid DIR_ACTIVE -> outputs IDLE/0 immediately; enable=0 mid-stun -> IDLE on the next clock without frame_tick.
